// File: rtl/mul_add.sv
// mul_add: sequential shift-and-add unit, p = a*b + c (unsigned); inverse of the iterative divider.
// Latency: WIDTH cycles from the accepted start edge to val=1 (early exit: max(1, msb(a)+1) cycles).
// Backpressure: start is accepted only while busy=0; p/val hold until the next accepted start.
// Optional feature macro: MUL_ADD_EARLY_EXIT_EN (ends the run as soon as no multiplier bits remain).
module mul_add #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               val,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [2*WIDTH-1:0] bs_q, bs_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               val_q, val_d;

  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   m_shr;
  logic               last;

  // Next-state logic: load operands on an accepted start, then one shift-and-add step per cycle.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    bs_d    = bs_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    val_d   = val_q;

    // acc never exceeds 2^(2W) - 2^W, so the 2W-bit sum cannot wrap.
    acc_sum = acc_q + (m_q[0] ? bs_q : '0);
    m_shr   = m_q >> 1;
`ifdef MUL_ADD_EARLY_EXIT_EN
    last    = (cnt_q == CNT_LAST) || (m_shr == '0);
`else
    last    = (cnt_q == CNT_LAST);
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          m_d     = a;
          bs_d    = {{WIDTH{1'b0}}, b};
          acc_d   = {{WIDTH{1'b0}}, c};
          cnt_d   = '0;
          val_d   = 1'b0;
        end
      end
      S_RUN: begin
        acc_d = acc_sum;
        m_d   = m_shr;
        bs_d  = bs_q << 1;
        cnt_d = cnt_q + CNT_ONE;
        // p only changes here, so a partial accumulation is never visible.
        if (last) begin
          state_d = S_IDLE;
          p_d     = acc_sum;
          val_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any run and clears the published result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      bs_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      bs_q    <= bs_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      val_q   <= val_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign val  = val_q;
  assign p    = p_q;

endmodule

// File: tb/tb_mul_add.sv
// tb_mul_add: directed checks of mul_add at WIDTH=6 plus a divider loopback sweep.
// Latency: expected latency derived per operand (early-exit aware).
// Backpressure: exercises start while busy and start held across the completion edge.
module tb_mul_add;

  localparam int W = 6;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           busy;
  logic           val;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [W-1:0]   c;
  logic [2*W-1:0] p;

  int n_chk  = 0;
  int n_pass = 0;

  mul_add #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .val   (val),
    .a     (a),
    .b     (b),
    .c     (c),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int lat_of(input logic [W-1:0] x);
`ifdef MUL_ADD_EARLY_EXIT_EN
    int l;
    l = 1;
    for (int i = 0; i < W; i++) if (x[i]) l = i + 1;
    return l;
`else
    return W;
`endif
  endfunction

  // Called #1 after an edge, cyc0 edges after the accepted start edge.
  task automatic wait_done(input int cyc0, input int exp_lat, input int exp_p);
    int cyc;
    cyc = cyc0;
    while (!val && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      if (!val) chk("busy_during_run", busy, 1);
    end
    chk("latency", cyc, exp_lat);
    chk("val_done", val, 1);
    chk("busy_done", busy, 0);
    chk("p", p, exp_p);
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ic, input int exp_p);
    @(negedge clk);
    a = ia; b = ib; c = ic; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Operands must not be re-sampled during the run.
    a = ~ia; b = ~ib; c = ~ic;
    chk("busy_after_start", busy, 1);
    chk("val_cleared", val, 0);
    wait_done(0, lat_of(ia), exp_p);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; c = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_val", val, 0);
    chk("reset_p", p, 0);
    @(negedge clk) rst_n = 1'b1;

    // Basic and maximum-operand cases.
    run_op(6'd3, 6'd3, 6'd2, 11);
    run_op(6'd63, 6'd63, 6'd62, 4031);

    // Start pulsed mid-run is ignored.
    @(negedge clk);
    a = 6'd5; b = 6'd7; c = 6'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_busy0", busy, 1);
    @(negedge clk);
    a = 6'd2; b = 6'd2; c = 6'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_busy1", busy, 1);
    wait_done(1, lat_of(6'd5), 36);
    run_op(6'd2, 6'd2, 6'd0, 4);

    // Zero multiplier returns the addend.
    run_op(6'd0, 6'd45, 6'd9, 9);
    run_op(6'd1, 6'd0, 6'd17, 17);

    // Start held high across the completion edge: accepted one edge later.
    @(negedge clk);
    a = 6'd3; b = 6'd3; c = 6'd2; start = 1'b1;
    @(posedge clk); #1;
    a = 6'd2; b = 6'd2; c = 6'd0;
    wait_done(0, lat_of(6'd3), 11);
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_val", val, 0);
    wait_done(0, lat_of(6'd2), 4);

    // Asynchronous reset in the third run cycle.
    @(negedge clk);
    a = 6'd63; b = 6'd63; c = 6'd62; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_val", val, 0);
    chk("abort_p", p, 0);
    @(negedge clk) rst_n = 1'b1;
    run_op(6'd63, 6'd63, 6'd62, 4031);
    run_op(6'd32, 6'd1, 6'd0, 32);

    // Divider loopback: (x / y) * y + (x % y) must give x back.
    for (int x = 0; x < 64; x++) begin
      for (int y = 1; y < 64; y++) begin
        run_op(6'(x / y), 6'(y), 6'(x % y), x);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
